// File: rtl/pipe_pattern_source_pkg.sv
// Shared definitions for the okPipeOut pattern source: generator mode
// encodings, LFSR tap positions and the LFSR next-state function.
// No ports; imported by the interface, FIFO and top-level files.
package pipe_pattern_source_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_LFSR    = 2'b01,
    MODE_COUNTER = 2'b10,
    MODE_RSVD    = 2'b11   // behaves like MODE_OFF
  } mode_e;

  localparam int LFSR_TAP_A = 31;
  localparam int LFSR_TAP_B = 21;
  localparam int LFSR_TAP_C = 1;

  // One step of the 32-bit Fibonacci LFSR: shift left, feed back XOR of taps.
  function automatic logic [31:0] lfsr_next(input logic [31:0] g);
    return {g[30:0], g[LFSR_TAP_A] ^ g[LFSR_TAP_B] ^ g[LFSR_TAP_C]};
  endfunction

endpackage

// File: rtl/pipe_pattern_source_if.sv
// Control/data bundle between a host-side driver and pipe_pattern_source.
// master: drives mode, gen_en, seed, seed_load, ep_read;
//         observes ep_datain, level, empty, full, underflow_cnt.
// slave : the pattern source itself (directions reversed).
interface pipe_pattern_source_if #(
  parameter int ADDR_W = 4
);
  logic [1:0]      mode;
  logic            gen_en;
  logic [31:0]     seed;
  logic            seed_load;
  logic            ep_read;
  logic [15:0]     ep_datain;
  logic [ADDR_W:0] level;
  logic            empty;
  logic            full;
  logic [15:0]     underflow_cnt;

  modport master (
    output mode, gen_en, seed, seed_load, ep_read,
    input  ep_datain, level, empty, full, underflow_cnt
  );

  modport slave (
    input  mode, gen_en, seed, seed_load, ep_read,
    output ep_datain, level, empty, full, underflow_cnt
  );
endinterface

// File: rtl/pipe_pattern_source_fifo.sv
// sync_fifo16: single-clock FIFO of 16-bit words.
// Ports: clk_i, rst_i (sync, active-high), flush_i (clears pointers),
//        wr_en_i/wr_data_i, rd_en_i/rd_data_o (head word, combinational),
//        level_o/empty_o/full_o (registered occupancy flags).
// The caller must only write when there is room (or a read happens in the
// same cycle) and only read when non-empty; flush overrides both.
module sync_fifo16 #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            wr_en_i,
  input  logic [15:0]     wr_data_i,
  input  logic            rd_en_i,
  output logic [15:0]     rd_data_o,
  output logic [ADDR_W:0] level_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam logic [ADDR_W:0] ONE_PTR   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO_PTR  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W+1)'(DEPTH);

  logic [15:0]     mem_q [DEPTH];
  // Pointers carry one extra MSB so that full and empty are distinguishable.
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;

  // Next pointer values and the occupancy flags derived from them.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = ZERO_PTR;
      rd_ptr_d = ZERO_PTR;
    end else begin
      if (wr_en_i) begin
        wr_ptr_d = wr_ptr_q + ONE_PTR;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_i) begin
        rd_ptr_d = rd_ptr_q + ONE_PTR;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
    level_d = wr_ptr_d - rd_ptr_d;
    empty_d = (level_d == ZERO_PTR);
    full_d  = (level_d == DEPTH_LVL);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= ZERO_PTR;
      rd_ptr_q <= ZERO_PTR;
      level_q  <= ZERO_PTR;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate access.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign level_o   = level_q;
  assign empty_o   = empty_q;
  assign full_o    = full_q;

endmodule

// File: rtl/pipe_pattern_source.sv
// pipe_pattern_source: LFSR/counter word source feeding okPipeOut (0xA0).
// Ports: ti_clk (single clock), reset (sync, active-high),
//        bus (slave modport): mode, gen_en, seed, seed_load, ep_read in;
//        ep_datain, level, empty, full, underflow_cnt out.
// Words are generated into a FIFO at the gen_en rate and popped on ep_read
// with registered-data timing: the head word lands in ep_datain on the same
// edge that samples ep_read.
module pipe_pattern_source
  import pipe_pattern_source_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter int          ADDR_W       = 4,
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
  input logic                  ti_clk,
  input logic                  reset,
  pipe_pattern_source_if.slave bus
);

  logic [31:0]     gen_q, gen_d;
  logic [15:0]     data_q, data_d;
  logic [15:0]     ucnt_q, ucnt_d;

  logic            mode_active_s;
  logic            pop_req_s;
  logic            pop_s;
  logic            underflow_s;
  logic            push_s;
  logic [15:0]     head_s;
  logic [ADDR_W:0] level_s;
  logic            empty_s;
  logic            full_s;

  // Push/pop qualification; seed_load suppresses both and flushes instead.
  always_comb begin
    mode_active_s = (bus.mode == MODE_LFSR) || (bus.mode == MODE_COUNTER);
    pop_req_s     = bus.ep_read & ~bus.seed_load;
    pop_s         = pop_req_s & ~empty_s;
    underflow_s   = pop_req_s & empty_s;
    // A full FIFO can still accept a word when a pop frees a slot this edge.
    push_s        = bus.gen_en & mode_active_s & ~bus.seed_load & (~full_s | pop_s);
  end

  // Generator next state: seed load wins, otherwise step only on a push.
  always_comb begin
    gen_d = gen_q;
    if (bus.seed_load) begin
      gen_d = bus.seed;
    end else if (push_s) begin
      case (bus.mode)
        MODE_LFSR:    gen_d = lfsr_next(gen_q);
        MODE_COUNTER: gen_d = gen_q + 32'd1;
        default:      gen_d = gen_q;
      endcase
    end else begin
      gen_d = gen_q;
    end
  end

  // Output word and saturating underflow counter next state.
  always_comb begin
    data_d = data_q;
    ucnt_d = ucnt_q;
    if (pop_s) begin
      data_d = head_s;
    end else if (underflow_s) begin
      data_d = 16'h0000;
    end else begin
      data_d = data_q;
    end
    if (underflow_s && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // Generator, output word and underflow counter registers.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      gen_q  <= SEED_DEFAULT;
      data_q <= 16'h0000;
      ucnt_q <= 16'h0000;
    end else begin
      gen_q  <= gen_d;
      data_q <= data_d;
      ucnt_q <= ucnt_d;
    end
  end

  sync_fifo16 #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i     (ti_clk),
    .rst_i     (reset),
    .flush_i   (bus.seed_load),
    .wr_en_i   (push_s),
    .wr_data_i (gen_q[15:0]),
    .rd_en_i   (pop_s),
    .rd_data_o (head_s),
    .level_o   (level_s),
    .empty_o   (empty_s),
    .full_o    (full_s)
  );

  assign bus.ep_datain     = data_q;
  assign bus.level         = level_s;
  assign bus.empty         = empty_s;
  assign bus.full          = full_s;
  assign bus.underflow_cnt = ucnt_q;

endmodule
